// File: rtl/pollard_pkg.sv
// pollard_pkg: shared types and timing helpers for the Pollard p-1 exponentiation datapath
package pollard_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, REDUCE, MUL, SQR, FIN} state_t;
    localparam int DEFAULT_WIDTH = 32;
    localparam int MUL_CYCLES = DEFAULT_WIDTH + 1;
    function automatic int mul_cycles(input int width);
        return width + 1;
    endfunction
endpackage

// File: rtl/mod_mult.sv
// mod_mult: interleaved MSB-first shift-add modular multiplier, p = a*b mod m (a < m)
module mod_mult
    import pollard_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             rdy,
    output logic [WIDTH-1:0] p
);
    localparam int ITERS = mul_cycles(WIDTH) - 1;
    localparam int CW = $clog2(ITERS + 1);
    logic [WIDTH-1:0] a_r, b_r, m_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   dbl, dbl_red, sum, sum_red;
    // both partial results stay below 2m, so a single conditional subtract each keeps them below m
    always_comb begin
        dbl     = {p, 1'b0};
        dbl_red = (dbl >= {1'b0, m_r}) ? dbl - {1'b0, m_r} : dbl;
        sum     = dbl_red + (b_r[WIDTH-1] ? {1'b0, a_r} : '0);
        sum_red = (sum >= {1'b0, m_r}) ? sum - {1'b0, m_r} : sum;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r <= '0;
            b_r <= '0;
            m_r <= '0;
            p   <= '0;
            cnt <= '0;
            rdy <= 1'b0;
        end else if (go) begin
            a_r <= a;
            b_r <= b;
            m_r <= m;
            p   <= '0;
            cnt <= CW'(ITERS);
            rdy <= 1'b0;
        end else begin
            rdy <= (cnt == CW'(1));
            if (cnt != '0) begin
                p   <= sum_red[WIDTH-1:0];
                b_r <= b_r << 1;
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/mod_exponentiation.sv
// mod_exponentiation: right-to-left binary modular exponentiation, result = base^exponent mod modulus
module mod_exponentiation
    import pollard_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 error
);
    state_t               state, next;
    logic [WIDTH-1:0]     base_r, mod_r, acc, bb, acc_next, b_next, op_a, op_b, p;
    logic [EXP_WIDTH-1:0] e, e_next;
    logic                 go, rdy, step, err_r;

    mod_mult #(.WIDTH(WIDTH)) u_mult (
        .clk(clk), .reset(reset), .go(go), .a(op_a), .b(op_b), .m(mod_r), .rdy(rdy), .p(p)
    );

    // the finished product is forwarded so the next multiply can launch on the same edge
    always_comb begin
        acc_next = (rdy && state == MUL) ? p : acc;
        b_next   = (rdy && (state == REDUCE || state == SQR)) ? p : bb;
        next     = state;
        e_next   = e;
        go       = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE:    if (start) next = CHECK;
            CHECK:   if (mod_r < WIDTH'(2)) next = FIN;
                     else begin next = REDUCE; go = 1'b1; end
            REDUCE:  if (rdy) begin
                         if (e == '0) next = FIN;
                         else if (e[0]) begin next = MUL; go = 1'b1; end
                         else step = 1'b1;
                     end
            MUL:     if (rdy) step = 1'b1;
            SQR:     if (rdy) begin
                         if (e[0]) begin next = MUL; go = 1'b1; end
                         else step = 1'b1;
                     end
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
        if (step) begin
            e_next = e >> 1;
            if (e_next == '0) next = FIN;
            else begin next = SQR; go = 1'b1; end
        end
        op_a = (next == REDUCE) ? WIDTH'(1) : (next == MUL) ? acc_next : b_next;
        op_b = (next == REDUCE) ? base_r : b_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            base_r <= '0;
            mod_r  <= '0;
            e      <= '0;
            acc    <= '0;
            bb     <= '0;
            err_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            error  <= 1'b0;
        end else begin
            state <= next;
            done  <= (state == FIN);
            bb    <= b_next;
            e     <= e_next;
            if (state == IDLE && start) begin
                base_r <= base;
                mod_r  <= modulus;
                e      <= exponent;
                busy   <= 1'b1;
            end
            if (state == CHECK) begin
                acc   <= (mod_r < WIDTH'(2)) ? '0 : WIDTH'(1);
                err_r <= (mod_r == '0);
            end else begin
                acc <= acc_next;
            end
            if (state == FIN) begin
                busy   <= 1'b0;
                result <= acc;
                error  <= err_r;
            end
        end
    end
endmodule

// File: tb/tb_mod_exponentiation.sv
// tb_mod_exponentiation: scoreboard bench for mod_exponentiation (WIDTH=32, EXP_WIDTH=16)
module tb_mod_exponentiation;
    typedef struct {
        logic [31:0] r;
        logic        er;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [31:0] base = '0, modulus = '0;
    logic [15:0] exponent = '0;
    logic        busy, done, error;
    logic [31:0] result;
    int          tests_run = 0, tests_failed = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    mod_exponentiation #(.WIDTH(32), .EXP_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy), .done(done), .result(result), .error(error)
    );

    function automatic logic [31:0] model(input logic [31:0] b, input logic [15:0] e, input logic [31:0] m);
        longint unsigned r, x, mm;
        if (m == 0) return 32'd0;
        mm = 64'(m);
        r = 64'd1 % mm;
        x = 64'(b) % mm;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[31:0];
    endfunction

    function automatic int lat_model(input logic [15:0] e, input logic [31:0] m);
        int k, msb;
        if (m < 2) return 2;
        k = 1;
        msb = 0;
        if (e != 0) begin
            for (int i = 0; i < 16; i++) if (e[i]) msb = i;
            k = 1 + $countones(e) + msb;
        end
        return 2 + 33 * k;
    endfunction

    task automatic do_op(input logic [31:0] b, input logic [15:0] e, input logic [31:0] m, input bit spam,
                         output logic [31:0] r, output logic er, output int lat,
                         output bit one, output bit busy_ok, output bit hold_ok);
        exp_t        x;
        logic [31:0] prev;
        bit          got;
        x.r = model(b, e, m);
        x.er = (m == 0);
        x.lat = lat_model(e, m);
        sb.push_back(x);
        prev = result;
        got = 0;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busy_ok = 1; hold_ok = 1;
        while (!got && lat < 5000) begin
            if (spam) begin
                start = 1'($urandom_range(0, 1));
                base = $urandom; exponent = 16'($urandom); modulus = $urandom;
            end
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                got = 1;
                if (busy) busy_ok = 0;
            end else begin
                if (!busy) busy_ok = 0;
                if (result !== prev) hold_ok = 0;
            end
        end
        start = 1'b0;
        if (!got) lat = -1;
        r = result;
        er = error;
        @(posedge clk);
        #1 one = !done;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, error, result} !== 35'd0) begin
            tests_failed++; $display("FAIL reset_state got busy=%b done=%b err=%b res=%0d want all 0", busy, done, error, result);
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x;
        do_op(32'd2, 16'd25, 32'd1000003, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== 32'd554333 || r !== x.r) begin tests_failed++; $display("FAIL basic_result got %0d want %0d", r, x.r); end
        tests_run++;
        if (er !== 1'b0) begin tests_failed++; $display("FAIL basic_error got %b want 0", er); end
        tests_run++;
        if (!one) begin tests_failed++; $display("FAIL basic_done_width got >1 cycle want 1 cycle"); end
    endtask

    task automatic test_latency();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x;
        do_op(32'd3, 16'd17, 32'd1000, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== x.r) begin tests_failed++; $display("FAIL lat_result got %0d want %0d", r, x.r); end
        tests_run++;
        if (lat !== 233 || lat !== x.lat) begin tests_failed++; $display("FAIL lat_cycles got %0d want %0d", lat, x.lat); end
        tests_run++;
        if (!bok) begin tests_failed++; $display("FAIL lat_busy got busy gap want high throughout"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x;
        logic [31:0] bs[3] = '{32'd5, 32'd11, 32'd5};
        logic [15:0] es[3] = '{16'd30, 16'd1, 16'd0};
        logic [31:0] ms[3] = '{32'd97, 32'd7, 32'd13};
        for (int i = 0; i < 3; i++) begin
            do_op(bs[i], es[i], ms[i], 0, r, er, lat, one, bok, hok);
            x = sb.pop_front();
            tests_run++;
            if (r !== x.r) begin tests_failed++; $display("FAIL b2b_result[%0d] got %0d want %0d", i, r, x.r); end
            tests_run++;
            if (lat !== x.lat) begin tests_failed++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, x.lat); end
            tests_run++;
            if (!hok) begin tests_failed++; $display("FAIL b2b_hold[%0d] result changed while busy", i); end
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (result !== 32'd1) begin tests_failed++; $display("FAIL b2b_idle_hold got %0d want 1", result); end
    endtask

    task automatic test_edges();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x;
        do_op(32'd7, 16'd5, 32'd0, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (er !== 1'b1 || r !== 32'd0 || r !== x.r) begin tests_failed++; $display("FAIL mod0 got err=%b res=%0d want err=1 res=0", er, r); end
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL mod0_latency got %0d want 2", lat); end
        do_op(32'd9, 16'd3, 32'd1, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (er !== 1'b0 || r !== 32'd0 || lat !== x.lat) begin tests_failed++; $display("FAIL mod1 got err=%b res=%0d lat=%0d want err=0 res=0 lat=%0d", er, r, lat, x.lat); end
        do_op(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== 32'd0 || r !== x.r || er !== 1'b0) begin tests_failed++; $display("FAIL max_operands got res=%0d err=%b want 0 0", r, er); end
        tests_run++;
        if (lat !== x.lat) begin tests_failed++; $display("FAIL max_latency got %0d want %0d", lat, x.lat); end
        do_op(32'd123456789, 16'd54321, 32'd4294967291, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== x.r) begin tests_failed++; $display("FAIL large_prime got %0d want %0d", r, x.r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x; bit saw_done;
        @(negedge clk);
        base = 32'd3; exponent = 16'd17; modulus = 32'd1000; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, error, result} !== 35'd0) begin
            tests_failed++; $display("FAIL async_reset got busy=%b done=%b err=%b res=%0d want all 0", busy, done, error, result);
        end
        saw_done = 0;
        repeat (4) begin @(posedge clk); #1 if (done) saw_done = 1; end
        @(negedge clk) reset = 1'b1;
        repeat (40) begin @(posedge clk); #1 if (done) saw_done = 1; end
        tests_run++;
        if (saw_done) begin tests_failed++; $display("FAIL reset_abort got done pulse want none"); end
        do_op(32'd2, 16'd25, 32'd1000003, 0, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== 32'd554333 || lat !== x.lat) begin tests_failed++; $display("FAIL post_reset got res=%0d lat=%0d want 554333 lat=%0d", r, lat, x.lat); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] r; logic er; int lat; bit one, bok, hok; exp_t x;
        do_op(32'd3, 16'd17, 32'd1000, 1, r, er, lat, one, bok, hok);
        x = sb.pop_front();
        tests_run++;
        if (r !== 32'd163 || r !== x.r) begin tests_failed++; $display("FAIL start_ignored got %0d want %0d", r, x.r); end
        tests_run++;
        if (lat !== 233) begin tests_failed++; $display("FAIL start_ignored_latency got %0d want 233", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_back_to_back();
        test_edges();
        test_reset_mid();
        test_start_ignored();
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
